instruction_queue: RTL and testbench

Decoupling FIFO between the precoder and the decode stage of the out-of-order core. Each cycle it accepts a variable-size group of up to INPUT_INST expanded 32-bit instructions with their PCs from the precoder. Each cycle it presents up to OUTPUT_INST oldest instructions, in program order, to decode. Flush empties it in one cycle for redirects.

---
 rtl/instruction_queue_pkg.sv | 24 ++
 rtl/instruction_queue_ram.sv | 32 +++
 rtl/instruction_queue.sv | 123 ++++++++++++
 tb/tb_instruction_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared constants, entry layout and the log2 helper used for every width
// derivation in the instruction queue.
package instruction_queue_pkg;

    localparam int XLEN    = 64;
    localparam int INST_W  = 32;
    localparam int ENTRY_W = INST_W + XLEN;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_queue_ram.sv
// Circular entry storage: WR_PORTS synchronous write ports and RD_PORTS
// combinational read ports; contents are never reset.
module instruction_queue_ram
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WR_PORTS = 4,
    parameter int RD_PORTS = 2,
    localparam int AW      = log2(DEPTH)
) (
    input  logic                               clock,
    input  logic [WR_PORTS-1:0]                wr_en,
    input  logic [WR_PORTS-1:0][AW-1:0]        wr_addr,
    input  logic [WR_PORTS-1:0][ENTRY_W-1:0]   wr_data,
    input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr,
    output logic [RD_PORTS-1:0][ENTRY_W-1:0]   rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write addresses of a group are consecutive modulo DEPTH, so they never collide.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
        end
    end

    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
        assign rd_data[gi] = mem[rd_addr[gi]];
    end

endmodule

// File: rtl/instruction_queue.sv
// Precoder-to-decode instruction FIFO. Optional same-cycle empty-queue bypass
// is enabled by defining INST_QUEUE_BYPASS_EN.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int INPUT_INST  = 4,
    parameter int OUTPUT_INST = 2,
    parameter int DEPTH       = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              precoder_valid,
    output logic                              precoder_ready,
    input  logic [INST_W*INPUT_INST-1:0]      precoder_instructions,
    input  logic [log2(INPUT_INST):0]         precoder_instruction_count,
    input  logic [XLEN*INPUT_INST-1:0]        precoder_PCs,
    output logic                              decode_valid,
    input  logic                              decode_ready,
    output logic [INST_W*OUTPUT_INST-1:0]     decode_instructions,
    output logic [log2(OUTPUT_INST):0]        decode_instruction_count,
    output logic [XLEN*OUTPUT_INST-1:0]       decode_PCs
);

    localparam int PTR_W = log2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int OUT_W = log2(OUTPUT_INST) + 1;
    localparam logic [OCC_W-1:0] READY_LIMIT = OCC_W'(DEPTH - INPUT_INST);
    localparam logic [OCC_W-1:0] OUT_MAX     = OCC_W'(OUTPUT_INST);

    logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic [OCC_W-1:0] in_count, stored_n, present_n, skip_n, push_n, pop_n;
    logic             bypass;

    logic [INPUT_INST-1:0]                 wr_en;
    logic [INPUT_INST-1:0][PTR_W-1:0]      wr_addr;
    logic [INPUT_INST-1:0][ENTRY_W-1:0]    wr_data;
    logic [OUTPUT_INST-1:0][PTR_W-1:0]     rd_addr;
    logic [OUTPUT_INST-1:0][ENTRY_W-1:0]   rd_data;

    always_comb begin
        in_count = OCC_W'(precoder_instruction_count);
        stored_n = (occ_reg > OUT_MAX) ? OUT_MAX : occ_reg;
`ifdef INST_QUEUE_BYPASS_EN
        bypass = reset && (occ_reg == '0) && precoder_valid && !flush;
`else
        bypass = 1'b0;
`endif
        present_n = bypass ? ((in_count > OUT_MAX) ? OUT_MAX : in_count) : stored_n;

        precoder_ready           = (occ_reg <= READY_LIMIT);
        decode_valid             = (present_n != '0);
        decode_instruction_count = OUT_W'(present_n);

        // Bypassed lanes consumed by decode never enter storage.
        skip_n = (bypass && decode_ready) ? present_n : '0;
        pop_n  = (decode_valid && decode_ready && !bypass) ? present_n : '0;
        push_n = (precoder_valid && precoder_ready) ? (in_count - skip_n) : '0;

        head_next = head_reg + PTR_W'(pop_n);
        tail_next = tail_reg + PTR_W'(push_n);
        occ_next  = occ_reg + push_n - pop_n;
        if (flush) begin
            head_next = '0;
            tail_next = '0;
            occ_next  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            occ_reg  <= occ_next;
        end
    end

    for (genvar gi = 0; gi < INPUT_INST; gi++) begin : g_wr
        entry_t lane_entry;
        always_comb begin
            lane_entry = '0;
            for (int l = 0; l < INPUT_INST; l++) begin
                if (OCC_W'(l) == OCC_W'(gi) + skip_n)
                    lane_entry = {precoder_PCs[XLEN*l +: XLEN], precoder_instructions[INST_W*l +: INST_W]};
            end
        end
        assign wr_en[gi]   = !flush && (OCC_W'(gi) < push_n);
        assign wr_addr[gi] = tail_reg + PTR_W'(gi);
        assign wr_data[gi] = lane_entry;
    end

    for (genvar gi = 0; gi < OUTPUT_INST; gi++) begin : g_rd
        entry_t shown;
        assign rd_addr[gi] = head_reg + PTR_W'(gi);
`ifdef INST_QUEUE_BYPASS_EN
        assign shown = bypass ? {precoder_PCs[XLEN*gi +: XLEN], precoder_instructions[INST_W*gi +: INST_W]}
                              : entry_t'(rd_data[gi]);
`else
        assign shown = entry_t'(rd_data[gi]);
`endif
        assign decode_instructions[INST_W*gi +: INST_W] = (OCC_W'(gi) < present_n) ? shown.inst : '0;
        assign decode_PCs[XLEN*gi +: XLEN]              = (OCC_W'(gi) < present_n) ? shown.pc : '0;
    end

    instruction_queue_ram #(
        .DEPTH    (DEPTH),
        .WR_PORTS (INPUT_INST),
        .RD_PORTS (OUTPUT_INST)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_instruction_queue.sv
// Table-driven bench for instruction_queue with a queue scoreboard modelling
// occupancy, ordering, flush and (when INST_QUEUE_BYPASS_EN is defined) bypass.
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    localparam int IN_N  = 4;
    localparam int OUT_N = 2;
    localparam int DEPTH = 8;
    localparam int NVEC  = 33;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush = 1'b0;
    logic                 precoder_valid = 1'b0;
    logic                 precoder_ready;
    logic [32*IN_N-1:0]   precoder_instructions = '0;
    logic [2:0]           precoder_instruction_count = '0;
    logic [64*IN_N-1:0]   precoder_PCs = '0;
    logic                 decode_valid;
    logic                 decode_ready = 1'b0;
    logic [32*OUT_N-1:0]  decode_instructions;
    logic [1:0]           decode_instruction_count;
    logic [64*OUT_N-1:0]  decode_PCs;

    instruction_queue #(
        .INPUT_INST  (IN_N),
        .OUTPUT_INST (OUT_N),
        .DEPTH       (DEPTH)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .flush                      (flush),
        .precoder_valid             (precoder_valid),
        .precoder_ready             (precoder_ready),
        .precoder_instructions      (precoder_instructions),
        .precoder_instruction_count (precoder_instruction_count),
        .precoder_PCs               (precoder_PCs),
        .decode_valid               (decode_valid),
        .decode_ready               (decode_ready),
        .decode_instructions        (decode_instructions),
        .decode_instruction_count   (decode_instruction_count),
        .decode_PCs                 (decode_PCs)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_s;

    typedef struct {
        logic v;
        int   cnt;
        logic dr;
        logic fl;
        int   exp_n;
        logic exp_ready;
    } vec_t;

    entry_s      sb[$];
    vec_t        vecs[NVEC];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] next_pc = 64'd100;
    logic [63:0] last_pc = 64'd0;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, update model, advance.
    task automatic step(input logic v, input int cnt, input logic dr, input logic fl,
                        output int got_n, output logic got_ready);
        int     sz;
        int     exp_n;
        int     skip;
        logic   exp_ready;
        logic   byp;
        entry_s e;
        entry_s inc[IN_N];
        for (int i = 0; i < IN_N; i++) begin
            inc[i].pc   = next_pc + 64'(4 * i);
            inc[i].inst = inst_of(inc[i].pc);
            if (i < cnt) begin
                precoder_PCs[64*i +: 64]          = inc[i].pc;
                precoder_instructions[32*i +: 32] = inc[i].inst;
            end else begin
                precoder_PCs[64*i +: 64]          = 64'hBAD0_0000_0000_0000 | 64'(i);
                precoder_instructions[32*i +: 32] = 32'hDEAD_0000 | 32'(i);
            end
        end
        precoder_valid             = v;
        precoder_instruction_count = 3'(cnt);
        decode_ready               = dr;
        flush                      = fl;
        @(negedge clock);

        sz        = sb.size();
        exp_ready = ((DEPTH - sz) >= IN_N);
`ifdef INST_QUEUE_BYPASS_EN
        byp = (sz == 0) && v && !fl;
`else
        byp = 1'b0;
`endif
        exp_n = byp ? ((cnt > OUT_N) ? OUT_N : cnt) : ((sz > OUT_N) ? OUT_N : sz);
        check("precoder_ready", 64'(precoder_ready), 64'(exp_ready));
        check("decode_valid", 64'(decode_valid), 64'(exp_n != 0));
        check("decode_count", 64'(decode_instruction_count), 64'(exp_n));
        for (int l = 0; l < OUT_N; l++) begin
            e.inst = '0;
            e.pc   = '0;
            if (l < exp_n) e = byp ? inc[l] : sb[l];
            check("lane_inst", 64'(decode_instructions[32*l +: 32]), 64'(e.inst));
            check("lane_pc", decode_PCs[64*l +: 64], e.pc);
        end
        got_n     = int'(decode_instruction_count);
        got_ready = precoder_ready;
        $display("cycle %0d: in v=%0b cnt=%0d dr=%0b fl=%0b | out valid=%0b count=%0d ready=%0b pc0=%0d pc1=%0d model=%0d",
                 cyc, v, cnt, dr, fl, decode_valid, decode_instruction_count, precoder_ready,
                 decode_PCs[63:0], decode_PCs[127:64], sz);

        if (fl) begin
            sb.delete();
            last_pc = '0;
        end else begin
            skip = 0;
            if (dr && exp_n > 0) begin
                for (int k = 0; k < exp_n; k++) begin
                    if (!byp) void'(sb.pop_front());
                    check("order", 64'(decode_PCs[64*k +: 64] > last_pc), 64'd1);
                    last_pc = decode_PCs[64*k +: 64];
                end
                if (byp) skip = exp_n;
            end
            if (v && exp_ready) begin
                for (int k = skip; k < cnt; k++) sb.push_back(inc[k]);
                next_pc += 64'(4 * cnt);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int   n;
        logic r;
        int   byp_en;
`ifdef INST_QUEUE_BYPASS_EN
        byp_en = 1;
`else
        byp_en = 0;
`endif
        // v, cnt, dr, fl, expected count, expected precoder_ready (registered-path behaviour)
        vecs[0]  = '{1'b1, 3, 1'b1, 1'b0, 0, 1'b1};
        vecs[1]  = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
        vecs[2]  = '{1'b0, 0, 1'b1, 1'b0, 1, 1'b1};
        vecs[3]  = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[4]  = '{1'b1, 4, 1'b0, 1'b0, 0, 1'b1};
        vecs[5]  = '{1'b1, 4, 1'b0, 1'b0, 2, 1'b1};
        vecs[6]  = '{1'b1, 4, 1'b0, 1'b0, 2, 1'b0};
        vecs[7]  = '{1'b1, 4, 1'b1, 1'b0, 2, 1'b0};
        vecs[8]  = '{1'b1, 4, 1'b0, 1'b0, 2, 1'b0};
        vecs[9]  = '{1'b1, 4, 1'b1, 1'b0, 2, 1'b0};
        vecs[10] = '{1'b1, 4, 1'b0, 1'b0, 2, 1'b1};
        vecs[11] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b0};
        vecs[12] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b0};
        vecs[13] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
        vecs[14] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
        vecs[15] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[16] = '{1'b1, 3, 1'b1, 1'b0, 0, 1'b1};
        vecs[17] = '{1'b1, 3, 1'b1, 1'b0, 2, 1'b1};
        vecs[18] = '{1'b1, 3, 1'b1, 1'b0, 2, 1'b1};
        vecs[19] = '{1'b1, 3, 1'b1, 1'b0, 2, 1'b0};
        vecs[20] = '{1'b1, 3, 1'b1, 1'b0, 2, 1'b1};
        vecs[21] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
        vecs[22] = '{1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
        vecs[23] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[24] = '{1'b1, 3, 1'b0, 1'b0, 0, 1'b1};
        vecs[25] = '{1'b1, 2, 1'b0, 1'b0, 2, 1'b1};
        vecs[26] = '{1'b1, 3, 1'b1, 1'b1, 2, 1'b0};
        vecs[27] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[28] = '{1'b1, 2, 1'b0, 1'b0, 0, 1'b1};
        vecs[29] = '{1'b1, 3, 1'b1, 1'b1, 2, 1'b1};
        vecs[30] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[31] = '{1'b1, 0, 1'b1, 1'b0, 0, 1'b1};
        vecs[32] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b1};

        // Reset held for 5 cycles, then released.
        repeat (5) @(posedge clock);
        #1;
        check("reset_hold_valid", 64'(decode_valid), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("reset_valid", 64'(decode_valid), 64'd0);
        check("reset_ready", 64'(precoder_ready), 64'd1);
        check("reset_count", 64'(decode_instruction_count), 64'd0);
        check("reset_pcs", decode_PCs[63:0] | decode_PCs[127:64], 64'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].v, vecs[i].cnt, vecs[i].dr, vecs[i].fl, n, r);
`ifndef INST_QUEUE_BYPASS_EN
            check("vec_count", 64'(n), 64'(vecs[i].exp_n));
            check("vec_ready", 64'(r), 64'(vecs[i].exp_ready));
`endif
        end

        // Latency from an empty queue: bypass shows lanes 0,1 at once, otherwise one cycle later.
        step(1'b1, 3, 1'b1, 1'b0, n, r);
        check("latency_first", 64'(n), (byp_en != 0) ? 64'd2 : 64'd0);
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        check("latency_second", 64'(n), (byp_en != 0) ? 64'd1 : 64'd2);
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        check("latency_third", 64'(n), (byp_en != 0) ? 64'd0 : 64'd1);
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        check("latency_drained", 64'(n), 64'd0);

        // Flush on an empty queue with an incoming group shows nothing.
        step(1'b1, 2, 1'b1, 1'b1, n, r);
        check("flush_empty_count", 64'(n), 64'd0);
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        check("after_flush_count", 64'(n), 64'd0);

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        step(1'b1, 3, 1'b0, 1'b0, n, r);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", 64'(decode_valid), 64'd0);
        check("async_reset_count", 64'(decode_instruction_count), 64'd0);
        check("async_reset_ready", 64'(precoder_ready), 64'd1);
        check("async_reset_pcs", decode_PCs[63:0] | decode_PCs[127:64], 64'd0);
        sb.delete();
        last_pc = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        check("post_reset_count", 64'(n), 64'd0);
        step(1'b1, 2, 1'b1, 1'b0, n, r);
        step(1'b0, 0, 1'b1, 1'b0, n, r);
        step(1'b0, 0, 1'b1, 1'b0, n, r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
